// File: rtl/sgdmac_sync_fifo_v2_if.sv
// Bus interface for the SGDMAC second-generation synchronous FIFO.
// peak_o is present only when SGDMAC_FIFO_PEAK_EN is defined.
interface sgdmac_sync_fifo_v2_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  wren_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rden_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  full_o;
    logic                  empty_o;
    logic [CNT_W-1:0]      afull_thr_i;
    logic [CNT_W-1:0]      aempty_thr_i;
    logic                  afull_o;
    logic                  aempty_o;
    logic [CNT_W-1:0]      cnt_o;
    logic [CNT_W-1:0]      free_o;
    logic                  flush_i;
    logic                  err_clr_i;
    logic                  ovf_o;
    logic                  udf_o;
`ifdef SGDMAC_FIFO_PEAK_EN
    logic [CNT_W-1:0]      peak_o;
`endif

    modport master (
        output wren_i, wdata_i, rden_i, afull_thr_i, aempty_thr_i, flush_i, err_clr_i,
        input  rdata_o, full_o, empty_o, afull_o, aempty_o, cnt_o, free_o, ovf_o, udf_o
`ifdef SGDMAC_FIFO_PEAK_EN
        , peak_o
`endif
    );

    modport slave (
        input  wren_i, wdata_i, rden_i, afull_thr_i, aempty_thr_i, flush_i, err_clr_i,
        output rdata_o, full_o, empty_o, afull_o, aempty_o, cnt_o, free_o, ovf_o, udf_o
`ifdef SGDMAC_FIFO_PEAK_EN
        , peak_o
`endif
    );
endinterface

// File: rtl/sgdmac_sync_fifo_v2.sv
// Synchronous show-ahead FIFO with arbitrary depth, runtime thresholds, flush and sticky errors.
// Optional high-water mark (peak_o) enabled by defining SGDMAC_FIFO_PEAK_EN.
module sgdmac_sync_fifo_v2 #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sgdmac_sync_fifo_v2_if.slave   fifo
);
    localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wrptr_q, wrptr_d;
    logic [PTR_W-1:0]      rdptr_q, rdptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full_c, empty_c;
    logic                  wr_acc_c, rd_acc_c;
    logic                  wr_err_c, rd_err_c;
`ifdef SGDMAC_FIFO_PEAK_EN
    logic [CNT_W-1:0]      peak_q, peak_d;
`endif

    // Pointers wrap by explicit compare so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c  = (count_q == DEPTH_C);
    assign empty_c = (count_q == '0);

    always_comb begin
        wr_acc_c = fifo.wren_i & ~full_c  & ~fifo.flush_i;
        rd_acc_c = fifo.rden_i & ~empty_c & ~fifo.flush_i;
        wr_err_c = fifo.wren_i &  full_c  & ~fifo.flush_i;
        rd_err_c = fifo.rden_i &  empty_c & ~fifo.flush_i;

        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        count_d = count_q;

        if (fifo.flush_i) begin
            wrptr_d = '0;
            rdptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_acc_c) begin
                wrptr_d = ptr_inc(wrptr_q);
            end
            if (rd_acc_c) begin
                rdptr_d = ptr_inc(rdptr_q);
            end
            unique case ({wr_acc_c, rd_acc_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error in the same cycle as a clear wins.
        ovf_d = (ovf_q & ~fifo.err_clr_i) | wr_err_c;
        udf_d = (udf_q & ~fifo.err_clr_i) | rd_err_c;

`ifdef SGDMAC_FIFO_PEAK_EN
        if (fifo.err_clr_i) begin
            peak_d = count_d;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end else begin
            peak_d = peak_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`ifdef SGDMAC_FIFO_PEAK_EN
            peak_q  <= '0;
`endif
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`ifdef SGDMAC_FIFO_PEAK_EN
            peak_q  <= peak_d;
`endif
        end
    end

    // Storage has no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_c) begin
            mem_q[wrptr_q] <= fifo.wdata_i;
        end
    end

    assign fifo.rdata_o  = mem_q[rdptr_q];
    assign fifo.full_o   = full_c;
    assign fifo.empty_o  = empty_c;
    assign fifo.cnt_o    = count_q;
    assign fifo.free_o   = DEPTH_C - count_q;
    assign fifo.afull_o  = (count_q >= fifo.afull_thr_i);
    assign fifo.aempty_o = (count_q <= fifo.aempty_thr_i);
    assign fifo.ovf_o    = ovf_q;
    assign fifo.udf_o    = udf_q;
`ifdef SGDMAC_FIFO_PEAK_EN
    assign fifo.peak_o   = peak_q;
`endif

endmodule

// File: tb/tb_sgdmac_sync_fifo_v2.sv
// Self-checking bench for sgdmac_sync_fifo_v2: DEPTH=16 directed table plus DEPTH=6 random stream.
module tb_sgdmac_sync_fifo_v2;
    logic clk;
    logic rst_n;

    sgdmac_sync_fifo_v2_if #(.DEPTH(16), .DATA_WIDTH(32)) if16 ();
    sgdmac_sync_fifo_v2_if #(.DEPTH(6),  .DATA_WIDTH(32)) if6 ();

    sgdmac_sync_fifo_v2 #(.DEPTH(16), .DATA_WIDTH(32)) dut16 (.clk(clk), .rst_n(rst_n), .fifo(if16));
    sgdmac_sync_fifo_v2 #(.DEPTH(6),  .DATA_WIDTH(32)) dut6  (.clk(clk), .rst_n(rst_n), .fifo(if6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        bit          fl;
        bit          ec;
        logic [31:0] d;
        int          cnt;
        bit          ovf;
        bit          udf;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb16[$];
    logic [31:0] sb6[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_step = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d act=%0h exp=%0h", nm, cur_step, act, exp);
        end
    endtask

    task automatic add(input bit wr, input bit rd, input bit fl, input bit ec,
                       input logic [31:0] d, input int cnt, input bit ovf, input bit udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.ec = ec; v.d = d;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        tbl.push_back(v);
    endtask

    // One clock on the DEPTH=16 FIFO: scoreboard the data, then compare status after the edge.
    task automatic step16(input vec_t v);
        int prior;
        logic [31:0] exp;
        if16.wren_i    = v.wr;
        if16.rden_i    = v.rd;
        if16.flush_i   = v.fl;
        if16.err_clr_i = v.ec;
        if16.wdata_i   = v.d;
        prior = sb16.size();
        if (v.rd && !v.fl && prior > 0) begin
            exp = sb16.pop_front();
            chk("rdata16", if16.rdata_o, exp);
        end
        if (v.fl) sb16.delete();
        else if (v.wr && prior < 16) sb16.push_back(v.d);
        @(posedge clk);
        #1;
        chk("cnt16",    32'(if16.cnt_o),  32'(v.cnt));
        chk("free16",   32'(if16.free_o), 32'(16 - v.cnt));
        chk("full16",   32'(if16.full_o), 32'(v.cnt == 16));
        chk("empty16",  32'(if16.empty_o), 32'(v.cnt == 0));
        chk("afull16",  32'(if16.afull_o), 32'(v.cnt >= int'(if16.afull_thr_i)));
        chk("aempty16", 32'(if16.aempty_o), 32'(v.cnt <= int'(if16.aempty_thr_i)));
        chk("ovf16",    32'(if16.ovf_o), 32'(v.ovf));
        chk("udf16",    32'(if16.udf_o), 32'(v.udf));
        cur_step++;
    endtask

    task automatic idle16();
        if16.wren_i = 1'b0; if16.rden_i = 1'b0; if16.flush_i = 1'b0; if16.err_clr_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   wsent, rcvd, cyc, prior;
        logic [31:0] exp;
        bit   wr, rd;

        rst_n = 1'b0;
        idle16();
        if16.wdata_i = '0;
        if16.afull_thr_i = 5'd0;
        if16.aempty_thr_i = 5'd2;
        if6.wren_i = 1'b0; if6.rden_i = 1'b0; if6.flush_i = 1'b0; if6.err_clr_i = 1'b0;
        if6.wdata_i = '0;
        if6.afull_thr_i = 3'd4;
        if6.aempty_thr_i = 3'd1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(if16.empty_o), 32'd1);
        chk("rst_full",  32'(if16.full_o),  32'd0);
        chk("rst_cnt",   32'(if16.cnt_o),   32'd0);
        chk("rst_free",  32'(if16.free_o),  32'd16);
        chk("rst_ovf",   32'(if16.ovf_o),   32'd0);
        chk("rst_udf",   32'(if16.udf_o),   32'd0);
        chk("rst_aempty", 32'(if16.aempty_o), 32'd1);
        chk("rst_afull_thr0", 32'(if16.afull_o), 32'd1);
        if16.afull_thr_i = 5'd12;
        #1;
        chk("rst_afull_thr12", 32'(if16.afull_o), 32'd0);
        rst_n = 1'b1;

        // Fill, overflow, clear, drain, underflow
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 32'(i), i + 1, 0, 0);
        add(1, 0, 0, 0, 32'h99, 16, 1, 0);
        add(0, 0, 0, 1, 32'h0, 16, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 32'h0, 15 - i, 0, 0);
        add(0, 1, 0, 0, 32'h0, 0, 0, 1);
        add(0, 0, 0, 1, 32'h0, 0, 0, 0);
        // Simultaneous read/write
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 32'h100 + 32'(i), i + 1, 0, 0);
        add(1, 1, 0, 0, 32'h103, 3, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 32'h0, 2 - i, 0, 0);
        add(1, 1, 0, 0, 32'h200, 1, 0, 1);
        add(0, 0, 0, 1, 32'h0, 1, 0, 0);
        add(0, 1, 0, 0, 32'h0, 0, 0, 0);
        // Error beats clear in the same cycle
        add(0, 1, 0, 1, 32'h0, 0, 0, 1);
        add(0, 0, 0, 1, 32'h0, 0, 0, 0);
        // Flush at cnt=5 with write and read
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 32'h300 + 32'(i), i + 1, 0, 0);
        add(1, 1, 1, 0, 32'h399, 0, 0, 0);
        add(0, 1, 1, 0, 32'h0, 0, 0, 0);
        add(1, 0, 0, 0, 32'h3AB, 1, 0, 0);
        add(0, 1, 0, 0, 32'h0, 0, 0, 0);
        // Flush at full suppresses ovf; sticky udf survives a flush
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 32'h400 + 32'(i), i + 1, 0, 0);
        add(1, 0, 1, 0, 32'h4FF, 0, 0, 0);
        add(0, 1, 0, 0, 32'h0, 0, 0, 1);
        add(0, 0, 1, 0, 32'h0, 0, 0, 1);
        add(0, 0, 0, 1, 32'h0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) step16(tbl[i]);

        // Live thresholds take effect without a clock edge
        for (int i = 0; i < 3; i++) begin
            v = '{wr: 1, rd: 0, fl: 0, ec: 0, d: 32'h500 + 32'(i), cnt: i + 1, ovf: 0, udf: 0};
            step16(v);
        end
        idle16();
        if16.afull_thr_i = 5'd3;  #1; chk("thr_afull_eq",   32'(if16.afull_o),  32'd1);
        if16.afull_thr_i = 5'd4;  #1; chk("thr_afull_gt",   32'(if16.afull_o),  32'd0);
        if16.aempty_thr_i = 5'd3; #1; chk("thr_aempty_eq",  32'(if16.aempty_o), 32'd1);
        if16.aempty_thr_i = 5'd2; #1; chk("thr_aempty_lt",  32'(if16.aempty_o), 32'd0);
        if16.afull_thr_i = 5'd12;

        // Reset mid-operation discards contents
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb16.delete();
        chk("midrst_cnt",   32'(if16.cnt_o),   32'd0);
        chk("midrst_empty", 32'(if16.empty_o), 32'd1);
        chk("midrst_free",  32'(if16.free_o),  32'd16);

`ifdef SGDMAC_FIFO_PEAK_EN
        chk("peak_rst", 32'(if16.peak_o), 32'd0);
        for (int i = 0; i < 9; i++)
            step16('{wr: 1, rd: 0, fl: 0, ec: 0, d: 32'h600 + 32'(i), cnt: i + 1, ovf: 0, udf: 0});
        for (int i = 0; i < 9; i++)
            step16('{wr: 0, rd: 1, fl: 0, ec: 0, d: 32'h0, cnt: 8 - i, ovf: 0, udf: 0});
        for (int i = 0; i < 4; i++)
            step16('{wr: 1, rd: 0, fl: 0, ec: 0, d: 32'h700 + 32'(i), cnt: i + 1, ovf: 0, udf: 0});
        chk("peak_hwm", 32'(if16.peak_o), 32'd9);
        step16('{wr: 0, rd: 0, fl: 0, ec: 1, d: 32'h0, cnt: 4, ovf: 0, udf: 0});
        chk("peak_clr", 32'(if16.peak_o), 32'd4);
        step16('{wr: 0, rd: 0, fl: 1, ec: 0, d: 32'h0, cnt: 0, ovf: 0, udf: 0});
        chk("peak_flush", 32'(if16.peak_o), 32'd4);
`endif
        idle16();

        // DEPTH=6 random stream across pointer wrap
        wsent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 20 && cyc < 2000) begin
            wr = (wsent < 20) && ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 1) != 0);
            if6.wren_i  = wr;
            if6.rden_i  = rd;
            if6.wdata_i = 32'hA000 + 32'(wsent);
            prior = sb6.size();
            if (rd && prior > 0) begin
                exp = sb6.pop_front();
                chk("rdata6", if6.rdata_o, exp);
                rcvd++;
            end
            if (wr && prior < 6) begin
                sb6.push_back(if6.wdata_i);
                wsent++;
            end
            @(posedge clk);
            #1;
            chk("cnt6",      32'(if6.cnt_o), 32'(sb6.size()));
            chk("cnt6_le",   32'(if6.cnt_o <= 3'd6), 32'd1);
            chk("sum6",      32'(if6.cnt_o) + 32'(if6.free_o), 32'd6);
            chk("afull6",    32'(if6.afull_o), 32'(sb6.size() >= 4));
            cyc++;
        end
        if6.wren_i = 1'b0;
        if6.rden_i = 1'b0;
        checks++;
        if (rcvd != 20) begin
            errors++;
            $display("FAIL stream6_timeout act=%0d exp=20", rcvd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
